// File: rtl/modport_fwd_pkg.sv
// modport_fwd_pkg -- shared types and constants for the MII transmit forwarder.
//   state_t         : transmit FSM states
//   PREAMBLE_NIBBLE : 0x5, repeated PREAMBLE_LEN times before the SFD nibble
//   SFD_NIBBLE      : 0xD, second half of the 0xD5 start-of-frame delimiter
//   CRC_POLY        : CRC-32 generator polynomial in normal (MSB-first) form
//   CRC_INIT        : CRC-32 preset value
//   reflect32()     : bit-reverse helper for deriving the LSB-first polynomial
package modport_fwd_pkg;

    typedef enum logic [2:0] {
        PHY_RST,
        IDLE,
        PREAMBLE,
        DATA,
        FCS,
        IFG
    } state_t;

    localparam logic [3:0]  PREAMBLE_NIBBLE = 4'h5;
    localparam logic [3:0]  SFD_NIBBLE      = 4'hD;
    localparam int unsigned PREAMBLE_LEN    = 15;
    localparam logic [31:0] CRC_POLY        = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT        = 32'hFFFFFFFF;

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/modport_fwd_if.sv
// modport_fwd_if -- byte stream handshake feeding the MII transmitter.
//   s_data  : payload byte
//   s_valid : s_data valid
//   s_last  : s_data is the final payload byte of the frame
//   s_ready : transmitter holding register empty; byte taken on s_valid && s_ready
// master drives the stream, slave (the transmitter) returns s_ready.
interface modport_fwd_if;

    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;

    modport master (output s_data, output s_valid, output s_last, input s_ready);
    modport slave  (input s_data, input s_valid, input s_last, output s_ready);

endinterface

// File: rtl/modport_fwd_crc32_mii.sv
// crc32_mii -- combinational CRC-32 update for one MII nibble.
//   crc_in  : running CRC register (reflected form)
//   nib     : nibble as it goes on the wire, bit 0 first
//   crc_out : CRC register after absorbing the nibble
// Bits are consumed LSB first, so the reflected polynomial is used.
module crc32_mii
    import modport_fwd_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [3:0]  nib,
    output logic [31:0] crc_out
);

    localparam logic [31:0] POLY_REFL = reflect32(CRC_POLY);

    always_comb begin
        logic [31:0] c;
        c = crc_in;
        for (int unsigned i = 0; i < 4; i++) begin
            if (c[0] ^ nib[i]) begin
                c = (c >> 1) ^ POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/modport_fwd.sv
// modport_fwd -- MII (100 Mb/s) transmit forwarder with PHY reset and ref clock.
// Ports:
//   clk, reset    : system clock (>= 4x tx_clk), synchronous active-high reset
//   s             : byte stream slave (s_data/s_valid/s_last in, s_ready out)
//   busy          : high from frame start through end of inter-frame gap
//   underrun      : one-clk pulse when a frame is aborted for lack of data
//   eth_crs       : carrier sense; defers a frame start while high
//   eth_mdc/mdio  : management port, parked (mdc low, mdio released)
//   eth_ref_clk   : PHY reference clock, clk / DIVIDER, free-running
//   eth_rstn      : PHY reset, low for RST_CYCLES clk after reset
//   eth_tx_clk    : PHY transmit clock; outputs advance after its falling edge
//   eth_tx_en/d   : MII transmit enable and nibble
// Build option: define MODPORT_FWD_FCS_EN to append a CRC-32 FCS over the payload;
// otherwise the frame ends with the last payload nibble.
module modport_fwd
    import modport_fwd_pkg::*;
#(
    parameter int unsigned DIVIDER     = 4,
    parameter int unsigned RST_CYCLES  = 200,
    parameter int unsigned IFG_NIBBLES = 24
) (
    input  logic         clk,
    input  logic         reset,
    modport_fwd_if.slave s,
    output logic         busy,
    output logic         underrun,
    input  logic         eth_crs,
    output logic         eth_mdc,
    inout  wire          eth_mdio,
    output logic         eth_ref_clk,
    output logic         eth_rstn,
    input  logic         eth_tx_clk,
    output logic         eth_tx_en,
    output logic [3:0]   eth_tx_d
);

    localparam int unsigned HALF = DIVIDER / 2;

    state_t      state;
    logic [31:0] rst_cnt;
    logic [15:0] div_cnt;
    logic [15:0] cnt;
    logic [2:0]  tx_sync;
    logic [1:0]  crs_sync;
    logic        tick;
    logic        crs_s;
    logic [7:0]  hold_data;
    logic        hold_last;
    logic        hold_full;
    logic [3:0]  cur_hi;
    logic        cur_last;
    logic        nib_hi;
    logic        accept;
    logic        take;

    assign eth_mdc  = 1'b0;
    assign eth_mdio = 1'bz;

    // [1:0] are the synchronizer, [2] is the previous synchronized value.
    assign tick  = tx_sync[2] & ~tx_sync[1];
    assign crs_s = crs_sync[1];

    assign s.s_ready = ~hold_full && (state != PHY_RST);
    assign accept    = s.s_valid && s.s_ready;
    assign take      = tick && (state == DATA) && !nib_hi && hold_full;

`ifdef MODPORT_FWD_FCS_EN
    logic [31:0] crc;
    logic [31:0] crc_next;
    logic [3:0]  crc_nib;

    assign crc_nib = nib_hi ? cur_hi : hold_data[3:0];

    crc32_mii u_crc (
        .crc_in  (crc),
        .nib     (crc_nib),
        .crc_out (crc_next)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_sync  <= '0;
            crs_sync <= '0;
        end else begin
            tx_sync  <= {tx_sync[1:0], eth_tx_clk};
            crs_sync <= {crs_sync[0], eth_crs};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt     <= '0;
            eth_ref_clk <= 1'b0;
        end else if (div_cnt == 16'(HALF - 1)) begin
            div_cnt     <= '0;
            eth_ref_clk <= ~eth_ref_clk;
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

    // Holding register: a new byte wins over a drain in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_full <= 1'b0;
            hold_data <= '0;
            hold_last <= 1'b0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_data <= s.s_data;
            hold_last <= s.s_last;
        end else if (take) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= PHY_RST;
            rst_cnt   <= '0;
            eth_rstn  <= 1'b0;
            eth_tx_en <= 1'b0;
            eth_tx_d  <= '0;
            busy      <= 1'b0;
            underrun  <= 1'b0;
            cnt       <= '0;
            cur_hi    <= '0;
            cur_last  <= 1'b0;
            nib_hi    <= 1'b0;
`ifdef MODPORT_FWD_FCS_EN
            crc       <= CRC_INIT;
`endif
        end else begin
            underrun <= 1'b0;
            if (state == PHY_RST) begin
                if (rst_cnt == 32'(RST_CYCLES - 1)) begin
                    eth_rstn <= 1'b1;
                    state    <= IDLE;
                end else begin
                    rst_cnt <= rst_cnt + 32'd1;
                end
            end else if (tick) begin
                case (state)
                    IDLE: begin
                        if (hold_full && !crs_s) begin
                            state     <= PREAMBLE;
                            eth_tx_en <= 1'b1;
                            eth_tx_d  <= PREAMBLE_NIBBLE;
                            cnt       <= 16'd1;
                            busy      <= 1'b1;
`ifdef MODPORT_FWD_FCS_EN
                            crc       <= CRC_INIT;
`endif
                        end
                    end
                    PREAMBLE: begin
                        if (cnt == 16'(PREAMBLE_LEN)) begin
                            eth_tx_d <= SFD_NIBBLE;
                            nib_hi   <= 1'b0;
                            state    <= DATA;
                        end else begin
                            eth_tx_d <= PREAMBLE_NIBBLE;
                            cnt      <= cnt + 16'd1;
                        end
                    end
                    DATA: begin
                        if (!nib_hi) begin
                            if (hold_full) begin
                                eth_tx_d <= hold_data[3:0];
                                cur_hi   <= hold_data[7:4];
                                cur_last <= hold_last;
                                nib_hi   <= 1'b1;
`ifdef MODPORT_FWD_FCS_EN
                                crc      <= crc_next;
`endif
                            end else begin
                                // Abort: this tick already counts as the first gap nibble.
                                eth_tx_en <= 1'b0;
                                eth_tx_d  <= '0;
                                underrun  <= 1'b1;
                                cnt       <= 16'd1;
                                state     <= IFG;
                            end
                        end else begin
                            eth_tx_d <= cur_hi;
                            nib_hi   <= 1'b0;
`ifdef MODPORT_FWD_FCS_EN
                            crc      <= crc_next;
`endif
                            if (cur_last) begin
                                cnt <= '0;
`ifdef MODPORT_FWD_FCS_EN
                                state <= FCS;
`else
                                state <= IFG;
`endif
                            end
                        end
                    end
                    FCS: begin
`ifdef MODPORT_FWD_FCS_EN
                        // FCS is the complemented register, sent LS nibble first.
                        eth_tx_d <= ~crc[3:0];
                        crc      <= {4'hF, crc[31:4]};
                        if (cnt == 16'd7) begin
                            cnt   <= '0;
                            state <= IFG;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
`else
                        state <= IFG;
`endif
                    end
                    IFG: begin
                        eth_tx_en <= 1'b0;
                        eth_tx_d  <= '0;
                        if (cnt >= 16'(IFG_NIBBLES - 1)) begin
                            cnt   <= '0;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_modport_fwd.sv
// tb_modport_fwd -- directed scoreboard bench for modport_fwd.
// Expected nibbles are queued as stimulus is issued; a monitor records every
// nibble driven with eth_tx_en high (sampled on the tx_clk falling edge, well
// away from output updates) and the stimulus thread compares them in order.
module tb_modport_fwd;

    typedef struct packed {
        logic [3:0]  nib;
        logic [31:0] tick;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       eth_crs = 1'b0;
    logic       eth_tx_clk = 1'b0;
    logic       busy, underrun, eth_mdc, eth_ref_clk, eth_rstn, eth_tx_en;
    logic [3:0] eth_tx_d;
    wire        eth_mdio;

    modport_fwd_if bus ();

    modport_fwd #(
        .DIVIDER     (4),
        .RST_CYCLES  (200),
        .IFG_NIBBLES (24)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .s           (bus.slave),
        .busy        (busy),
        .underrun    (underrun),
        .eth_crs     (eth_crs),
        .eth_mdc     (eth_mdc),
        .eth_mdio    (eth_mdio),
        .eth_ref_clk (eth_ref_clk),
        .eth_rstn    (eth_rstn),
        .eth_tx_clk  (eth_tx_clk),
        .eth_tx_en   (eth_tx_en),
        .eth_tx_d    (eth_tx_d)
    );

    always #5 clk = ~clk;

    initial begin
        #2;
        forever #20 eth_tx_clk = ~eth_tx_clk;
    end

    obs_t        obs[$];
    int unsigned tick_no = 0;
    int unsigned under_cnt = 0;

    always @(negedge eth_tx_clk) begin
        if (eth_tx_en === 1'b1) obs.push_back('{nib: eth_tx_d, tick: tick_no});
        tick_no = tick_no + 1;
    end

    always @(negedge clk) begin
        if (underrun === 1'b1) under_cnt = under_cnt + 1;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout observed=hung expected=finish");
        $fatal(1);
    end

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [3:0]  exp_q[$];
    logic [7:0]  frame_q[$];
    int unsigned rd_idx = 0;

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic exp_preamble();
        repeat (15) exp_q.push_back(4'h5);
        exp_q.push_back(4'hD);
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Queue the full expected frame for the bytes in frame_q.
    task automatic expect_frame();
        logic [31:0] c;
        logic [31:0] f;
        c = 32'hFFFFFFFF;
        exp_preamble();
        foreach (frame_q[i]) begin
            exp_q.push_back(frame_q[i][3:0]);
            exp_q.push_back(frame_q[i][7:4]);
            c = crc_byte(c, frame_q[i]);
        end
        f = ~c;
`ifdef MODPORT_FWD_FCS_EN
        for (int k = 0; k < 8; k++) exp_q.push_back(f[4*k +: 4]);
`endif
    endtask

    task automatic push_byte(input logic [7:0] d, input logic l);
        int unsigned n;
        n = 0;
        @(negedge clk);
        bus.s_data  = d;
        bus.s_last  = l;
        bus.s_valid = 1'b1;
        while (bus.s_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", bus.s_ready, 1);
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic send_frame();
        foreach (frame_q[i]) push_byte(frame_q[i], (i == frame_q.size() - 1));
    endtask

    task automatic wait_frame_done();
        int unsigned n;
        n = 0;
        while (busy !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        n = 0;
        while (busy !== 1'b0 && n < 4000) begin @(negedge clk); n++; end
        check("frame_done", busy, 0);
    endtask

    task automatic wait_tx_en(input logic lvl, input string tag);
        int unsigned n;
        n = 0;
        while (eth_tx_en !== lvl && n < 600) begin @(negedge clk); n++; end
        check(tag, eth_tx_en, lvl);
    endtask

    task automatic check_frame(input string tag);
        int unsigned n;
        logic [3:0]  e;
        check({tag, "_len"}, obs.size() - rd_idx, exp_q.size());
        n = exp_q.size();
        for (int unsigned i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            if (rd_idx < obs.size()) begin
                check($sformatf("%s_nib%0d", tag, i), obs[rd_idx].nib, e);
                rd_idx++;
            end
        end
    endtask

    task automatic count_rstn(input string tag);
        int unsigned n;
        int unsigned bad;
        n = 0;
        bad = 0;
        while (eth_rstn !== 1'b1 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
            if (eth_rstn !== 1'b1 && bus.s_ready !== 1'b0) bad++;
        end
        check(tag, n, 200);
        check({tag, "_sready_low"}, bad, 0);
        check({tag, "_sready_up"}, bus.s_ready, 1);
    endtask

    initial begin
        int unsigned n;
        int unsigned u0;
        int unsigned idx0;
        logic        prev;

        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.s_valid = 1'b0;

        // Reset state
        repeat (5) @(negedge clk);
        check("rst_tx_en", eth_tx_en, 0);
        check("rst_tx_d", eth_tx_d, 0);
        check("rst_ref_clk", eth_ref_clk, 0);
        check("rst_rstn", eth_rstn, 0);
        check("rst_s_ready", bus.s_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_underrun", underrun, 0);
        check("mdc", eth_mdc, 0);
        checks++;
        assert (eth_mdio === 1'bz) else begin
            errors++;
            $error("FAIL mdio observed=%b expected=z", eth_mdio);
        end

        reset = 1'b0;
        count_rstn("rstn_low_clks");

        // Reference clock: 4 clk period
        n = 0;
        prev = eth_ref_clk;
        @(negedge clk);
        while (!(prev === 1'b0 && eth_ref_clk === 1'b1) && n < 20) begin
            prev = eth_ref_clk;
            @(negedge clk);
            n++;
        end
        n = 0;
        prev = eth_ref_clk;
        @(negedge clk);
        n++;
        while (!(prev === 1'b0 && eth_ref_clk === 1'b1) && n < 20) begin
            prev = eth_ref_clk;
            @(negedge clk);
            n++;
        end
        check("ref_clk_period", n, 4);

        // Basic two-byte frame
        frame_q = '{8'hA5, 8'h3C};
        expect_frame();
`ifndef MODPORT_FWD_FCS_EN
        check("frame1_exp_len", exp_q.size(), 20);
`endif
        send_frame();
        wait_frame_done();
        check_frame("frame1");

`ifdef MODPORT_FWD_FCS_EN
        // CRC check value of "123456789" is 0xCBF43926
        frame_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        exp_preamble();
        foreach (frame_q[i]) begin
            exp_q.push_back(frame_q[i][3:0]);
            exp_q.push_back(frame_q[i][7:4]);
        end
        exp_q.push_back(4'h6); exp_q.push_back(4'h2); exp_q.push_back(4'h9); exp_q.push_back(4'h3);
        exp_q.push_back(4'h4); exp_q.push_back(4'hF); exp_q.push_back(4'hB); exp_q.push_back(4'hC);
        send_frame();
        wait_frame_done();
        check_frame("fcs");
`endif

        // Carrier sense defers the start
        eth_crs = 1'b1;
        repeat (3) @(negedge clk);
        frame_q = '{8'h5A};
        expect_frame();
        n = obs.size();
        send_frame();
        repeat (40) @(negedge clk);
        check("crs_no_tx_en", eth_tx_en, 0);
        check("crs_no_busy", busy, 0);
        check("crs_no_nibbles", obs.size(), n);
        check("crs_held_full", bus.s_ready, 0);
        eth_crs = 1'b0;
        n = 0;
        while (eth_tx_en !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check("crs_start_next_tick", (n <= 8), 1);
        wait_frame_done();
        check_frame("crs");

        // Underrun after first of three bytes, then preload during IFG
        u0 = under_cnt;
        idx0 = rd_idx;
        exp_preamble();
        exp_q.push_back(4'h1);
        exp_q.push_back(4'h1);
        push_byte(8'h11, 1'b0);
        wait_tx_en(1'b1, "ur_start");
        wait_tx_en(1'b0, "ur_drop");
        @(negedge clk);
        check("ur_busy_in_ifg", busy, 1);
        check("ur_ready_in_ifg", bus.s_ready, 1);
        check("ur_tx_d_zero", eth_tx_d, 0);
        frame_q = '{8'h77};
        expect_frame();
        send_frame();
        wait_tx_en(1'b1, "ur_next_start");
        wait_frame_done();
        check("ur_pulses", under_cnt - u0, 1);
        if (obs.size() >= idx0 + 19)
            check("ur_ifg_gap", obs[idx0 + 18].tick - obs[idx0 + 17].tick, 25);
        else
            check("ur_ifg_gap_len", obs.size(), idx0 + 19);
        check_frame("ur");

        // Reset during DATA
        push_byte(8'h11, 1'b0);
        push_byte(8'h22, 1'b0);
        repeat (2) @(negedge clk);
        check("mid_tx_en_before", eth_tx_en, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_tx_en", eth_tx_en, 0);
        check("mid_rstn", eth_rstn, 0);
        check("mid_busy", busy, 0);
        check("mid_s_ready", bus.s_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        count_rstn("mid_rstn_low_clks");
        exp_q.delete();
        rd_idx = obs.size();

        // Recovery frame
        frame_q = '{8'hC3};
        expect_frame();
        send_frame();
        wait_frame_done();
        check_frame("recover");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
